// File: rtl/mux_rr_sched_if.sv
// Bundle of the scheduler's request, mux-select, mux-data and downstream valid/ready signals.
// master: the scheduler side; slave: requesters, external mux and downstream consumer.
interface mux_rr_sched_if #(
  parameter int NUM_REQ = 31,
  parameter int DW      = 2,
  parameter int SELW    = 5
);
  logic [NUM_REQ-1:0] req;
  logic [SELW-1:0]    sel;
  logic [NUM_REQ-1:0] grant;
  logic [DW-1:0]      mux_out;
  logic [DW-1:0]      out_data;
  logic               out_valid;
  logic               out_ready;
  logic               busy;

  modport master (
    input  req, mux_out, out_ready,
    output sel, grant, out_data, out_valid, busy
  );

  modport slave (
    output req, mux_out, out_ready,
    input  sel, grant, out_data, out_valid, busy
  );
endinterface

// File: rtl/mux_rr_sched.sv
// Round-robin scheduler driving the select of an external 31:1 mux and forwarding the captured beat
// on a valid/ready handshake. Optional multi-beat grants are enabled by defining MUX_SCHED_BURST_EN.
module mux_rr_sched #(
  parameter int NUM_REQ   = 31,
  parameter int DW        = 2,
  parameter int SELW      = 5,
  parameter int BURST_LEN = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  mux_rr_sched_if.master bus
);

  localparam int BW = $clog2(BURST_LEN + 1);
`ifdef MUX_SCHED_BURST_EN
  localparam logic [BW-1:0] BEAT_LIMIT = BW'(BURST_LEN);
`else
  localparam logic [BW-1:0] BEAT_LIMIT = BW'(1);
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SELECT = 2'd1,
    S_SEND   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [SELW-1:0]    sel_q, sel_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [DW-1:0]      out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic [SELW-1:0]    last_ptr_q, last_ptr_d;
  logic [BW-1:0]      beats_q, beats_d;
  logic               busy_s;
  logic               req_any_s;
  logic               accept_s;
  logic               burst_more_s;
  logic [SELW-1:0]    pick_s;

  // First requesting index strictly after 'last', wrapping NUM_REQ-1 -> 0 (last itself is checked last).
  function automatic logic [SELW-1:0] rr_pick(input logic [NUM_REQ-1:0] r, input logic [SELW-1:0] last);
    logic [SELW-1:0] idx;
    logic            hit;
    logic [SELW:0]   cand;
    idx = '0;
    hit = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = {1'b0, last} + (SELW + 1)'(off);
      if (cand >= (SELW + 1)'(NUM_REQ)) begin
        cand = cand - (SELW + 1)'(NUM_REQ);
      end else begin
        cand = cand;
      end
      if (!hit && r[cand[SELW-1:0]]) begin
        idx = cand[SELW-1:0];
        hit = 1'b1;
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  assign req_any_s    = |bus.req;
  assign accept_s     = out_valid_q & bus.out_ready;
  assign pick_s       = rr_pick(bus.req, last_ptr_q);
  // Without the burst macro BEAT_LIMIT is 1 and the counter sits at 1, so this is never true.
  assign burst_more_s = (|(bus.req & grant_q)) && (beats_q < BEAT_LIMIT);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_any_s) begin
          state_d = S_SELECT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SELECT: begin
        state_d = S_SEND;
      end
      S_SEND: begin
        if (accept_s) begin
          state_d = burst_more_s ? S_SELECT : S_IDLE;
        end else begin
          state_d = S_SEND;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output / datapath next values; everything holds unless the current state updates it.
  always_comb begin
    sel_d       = sel_q;
    grant_d     = grant_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    last_ptr_d  = last_ptr_q;
    beats_d     = beats_q;
    busy_s      = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (req_any_s) begin
          sel_d   = pick_s;
          grant_d = {{(NUM_REQ - 1){1'b0}}, 1'b1} << pick_s;
          beats_d = BW'(1);
        end else begin
          sel_d   = '0;
          grant_d = '0;
        end
      end
      S_SELECT: begin
        out_data_d  = bus.mux_out;
        out_valid_d = 1'b1;
      end
      S_SEND: begin
        if (accept_s) begin
          out_valid_d = 1'b0;
          if (burst_more_s) begin
            beats_d = beats_q + BW'(1);
          end else begin
            sel_d      = '0;
            grant_d    = '0;
            last_ptr_d = sel_q;
          end
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        sel_d       = '0;
        grant_d     = '0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // Datapath registers; last_ptr resets to NUM_REQ-1 so the first search starts at index 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q       <= '0;
      grant_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      last_ptr_q  <= SELW'(NUM_REQ - 1);
      beats_q     <= '0;
    end else begin
      sel_q       <= sel_d;
      grant_q     <= grant_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      last_ptr_q  <= last_ptr_d;
      beats_q     <= beats_d;
    end
  end

  assign bus.sel       = sel_q;
  assign bus.grant     = grant_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_s;

endmodule

// File: tb/tb_mux_rr_sched.sv
// Bench for mux_rr_sched: transaction-level round-robin model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic with backpressure and a mid-run reset.
module tb_mux_rr_sched;

  localparam int N = 31;
`ifdef MUX_SCHED_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [1:0] mux_tbl [0:31];
  int         errors;
  int         checks;

  mux_rr_sched_if #(.NUM_REQ(N), .DW(2), .SELW(5)) bus ();

  mux_rr_sched #(.NUM_REQ(N), .DW(2), .SELW(5), .BURST_LEN(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.mux_out = mux_tbl[bus.sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: stage 0 = waiting for requests, 1 = grant issued / mux settling, 2 = beat offered.
  int         m_stage;
  int         m_last;
  int         m_idx;
  int         m_beats;
  logic [1:0] m_data;
  logic       m_valid;
  int         m_glog[$];
  int         m_blog[$];
  int         d_glog[$];
  int         d_blog[$];
  logic [N-1:0] prev_grant;

  function automatic int rr_model(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) begin
      if (g[i]) return i;
    end
    return -1;
  endfunction

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_stage <= 0;
      m_last  <= N - 1;
      m_idx   <= 0;
      m_beats <= 0;
      m_data  <= 2'b00;
      m_valid <= 1'b0;
    end else begin
      case (m_stage)
        0: begin
          if (bus.req != '0) begin
            m_idx   <= rr_model(bus.req, m_last);
            m_beats <= 1;
            m_stage <= 1;
            m_glog.push_back(rr_model(bus.req, m_last));
          end
        end
        1: begin
          m_data  <= mux_tbl[m_idx];
          m_valid <= 1'b1;
          m_stage <= 2;
        end
        2: begin
          if (bus.out_ready) begin
            m_valid <= 1'b0;
            m_blog.push_back(m_idx);
            if (BURST && bus.req[m_idx] && m_beats < 4) begin
              m_beats <= m_beats + 1;
              m_stage <= 1;
            end else begin
              m_last  <= m_idx;
              m_stage <= 0;
            end
          end
        end
        default: m_stage <= 0;
      endcase
    end
  end

  always @(posedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) d_blog.push_back(int'(bus.sel));
  end

  // Every-cycle comparison of all DUT outputs against the model.
  always @(negedge clk) begin
    logic [31:0] exp_grant;
    exp_grant = (m_stage != 0) ? (32'h1 << m_idx) : 32'h0;
    chk("sel",       32'(bus.sel),       (m_stage != 0) ? 32'(m_idx) : 32'h0);
    chk("grant",     32'(bus.grant),     exp_grant);
    chk("busy",      32'(bus.busy),      32'(m_stage != 0));
    chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
    chk("out_data",  32'(bus.out_data),  32'(m_data));
    if (bus.grant != '0 && prev_grant == '0) d_glog.push_back(onehot_idx(bus.grant));
    prev_grant = bus.grant;
  end

  task automatic wait_stage(input int s, input string nm);
    int n;
    n = 0;
    while (m_stage != s && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_timeout"}, 32'(n < 60), 32'h1);
  endtask

  task automatic clear_logs();
    m_glog.delete();
    m_blog.delete();
    d_glog.delete();
    d_blog.delete();
  endtask

  initial begin
    int n;
    int bad_m;
    int bad_d;
    int mode;
    int exp6 [8];
    errors     = 0;
    checks     = 0;
    prev_grant = '0;
    rst_n      = 1'b0;
    bus.req       = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 32; i++) mux_tbl[i] = 2'($urandom_range(0, 3));

    repeat (3) @(negedge clk);
    chk("rst_sel",   32'(bus.sel),       32'h0);
    chk("rst_grant", 32'(bus.grant),     32'h0);
    chk("rst_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_busy",  32'(bus.busy),      32'h0);
    chk("rst_data",  32'(bus.out_data),  32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // T2: single requester 5.
    bus.req       = 31'h1 << 5;
    mux_tbl[5]    = 2'b10;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("t2_sel",   32'(bus.sel),       32'h5);
    chk("t2_grant", 32'(bus.grant),     32'h20);
    chk("t2_valid0", 32'(bus.out_valid), 32'h0);
    bus.req = '0;
    @(negedge clk);
    chk("t2_valid", 32'(bus.out_valid), 32'h1);
    chk("t2_data",  32'(bus.out_data),  32'h2);
    @(negedge clk);
    chk("t2_busy",  32'(bus.busy),      32'h0);
    chk("t2_valid2", 32'(bus.out_valid), 32'h0);

    // T1: reset asserted mid-SEND.
    bus.req       = {N{1'b1}};
    bus.out_ready = 1'b0;
    wait_stage(2, "t1_send");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_valid", 32'(bus.out_valid), 32'h0);
    chk("t1_grant", 32'(bus.grant),     32'h0);
    chk("t1_sel",   32'(bus.sel),       32'h0);
    chk("t1_busy",  32'(bus.busy),      32'h0);
    @(negedge clk);
    clear_logs();
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("t1_first_grant", 32'(bus.grant), 32'h1);
    chk("t1_first_busy",  32'(bus.busy),  32'h1);

    // T3: full rotation, 93 beats.
    n = 0;
    while (m_glog.size() < 93 && n < 400) begin
      @(negedge clk);
      n++;
    end
    bus.req = '0;
    wait_stage(0, "t3_idle");
    repeat (2) @(negedge clk);
    chk("t3_model_len", 32'(m_glog.size()), 32'd93);
    chk("t3_dut_len",   32'(d_glog.size()), 32'd93);
    bad_m = 0;
    bad_d = 0;
    for (int i = 0; i < 93; i++) begin
      if (i >= m_glog.size() || m_glog[i] != i % N) bad_m++;
      if (i >= d_glog.size() || d_glog[i] != i % N) bad_d++;
    end
    chk("t3_model_order", 32'(bad_m), 32'h0);
    chk("t3_dut_order",   32'(bad_d), 32'h0);

    // T4: backpressure for 10 cycles while the mux input toggles.
    mux_tbl[12]   = 2'b01;
    bus.req       = 31'h1 << 12;
    bus.out_ready = 1'b0;
    wait_stage(2, "t4_send");
    bus.req = '0;
    for (int i = 0; i < 10; i++) begin
      mux_tbl[12] = 2'($urandom_range(0, 3));
      @(negedge clk);
      chk("t4_hold_valid", 32'(bus.out_valid), 32'h1);
      chk("t4_hold_data",  32'(bus.out_data),  32'h1);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("t4_accept_valid", 32'(bus.out_valid), 32'h0);
    chk("t4_accept_busy",  32'(bus.busy),      32'h0);

    // T5: move last_ptr to 30, then request {3,30} with a late bit pulsed during the beat of 3.
    bus.req = 31'h1 << 30;
    wait_stage(1, "t5_pre");
    bus.req = '0;
    wait_stage(0, "t5_pre_idle");
    bus.req = (31'h1 << 3) | (31'h1 << 30);
    wait_stage(1, "t5_g3");
    chk("t5_grant3", 32'(bus.grant), 32'h8);
    bus.req[1] = 1'b1;
    @(negedge clk);
    bus.req[1] = 1'b0;
    wait_stage(1, "t5_g30");
    chk("t5_grant30", 32'(bus.grant), 32'h4000_0000);
    chk("t5_sel30",   32'(bus.sel),   32'd30);
    bus.req = '0;
    wait_stage(0, "t5_idle");

    // T6: requesters 7 and 8 held high.
    clear_logs();
    if (BURST) begin
      exp6 = '{7, 7, 7, 7, 8, 8, 8, 8};
    end else begin
      exp6 = '{7, 8, 7, 8, 7, 8, 7, 8};
    end
    bus.req = (31'h1 << 7) | (31'h1 << 8);
    n = 0;
    while (m_blog.size() < 8 && n < 100) begin
      @(negedge clk);
      n++;
    end
    bus.req = '0;
    wait_stage(0, "t6_idle");
    bad_m = 0;
    bad_d = 0;
    for (int i = 0; i < 8; i++) begin
      if (i >= m_blog.size() || m_blog[i] != exp6[i]) bad_m++;
      if (i >= d_blog.size() || d_blog[i] != exp6[i]) bad_d++;
    end
    chk("t6_model_beats", 32'(bad_m), 32'h0);
    chk("t6_dut_beats",   32'(bad_d), 32'h0);

    // Randomized traffic; the per-cycle compare process does the checking.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      mode = int'($urandom_range(0, 3));
      case (mode)
        0: bus.req = '0;
        1: bus.req = 31'h1 << $urandom_range(0, N - 1);
        2: bus.req = 31'($urandom);
        default: bus.req = bus.req;
      endcase
      bus.out_ready = ($urandom_range(0, 3) != 0);
      for (int j = 0; j < 32; j++) mux_tbl[j] = 2'($urandom_range(0, 3));
      if (i == 300) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    bus.req = '0;
    bus.out_ready = 1'b1;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
